// File: rtl/line_feeder_nx2d.sv
`timescale 1ns/1ps
// Column-major strip reader that feeds an N-channel line buffer bank and flags full windows.
// Optional feature macro: LINE_FEEDER_STALL_CNT_EN adds a saturating pause-cycle counter (stall_cnt).
module line_feeder_nx2d #(
  parameter int filterSize     = 5,
  parameter int NoOfChannels   = 4,
  parameter int filterBitWidth = 12,
  parameter int IMG_W          = 64,
  parameter int IMG_H          = 64,
  parameter int ADDR_W         = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic                                          pause,
  output logic                                          mem_rd_en,
  output logic [ADDR_W-1:0]                             mem_addr,
  input  logic [NoOfChannels*filterBitWidth-1:0]        mem_rdata,
  output logic                                          buf_en,
  output logic signed [NoOfChannels*filterBitWidth-1:0] buf_d,
  output logic                                          win_valid,
  output logic [$clog2(IMG_H)-1:0]                      win_row,
  output logic [$clog2(IMG_W)-1:0]                      win_col,
  output logic                                          busy,
  output logic                                          done
`ifdef LINE_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                                   stall_cnt
`endif
);

  localparam int KW = (filterSize > 1) ? $clog2(filterSize) : 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [KW-1:0] K_LAST    = KW'(filterSize - 1);
  localparam logic [CW-1:0] C_LAST    = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST    = RW'(IMG_H - filterSize);
  localparam logic [CW-1:0] C_WIN_MIN = CW'(filterSize - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic          rd_en;

  logic          buf_en_q;
  logic          rd_win_q;
  logic [RW-1:0] tag_r_q;
  logic [CW-1:0] tag_c_q;
  logic          win_valid_q;
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    r_d     = r_q;
    rd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
          c_d     = '0;
          r_d     = '0;
        end
      end
      S_RUN: begin
        if (!pause) begin
          rd_en = 1'b1;
          if (k_q == K_LAST) begin
            k_d = '0;
            if (c_q == C_LAST) begin
              c_d = '0;
              if (r_q == R_LAST) begin
                r_d     = '0;
                state_d = S_DRAIN;
              end else begin
                r_d = r_q + RW'(1);
              end
            end else begin
              c_d = c_q + CW'(1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      buf_en_q    <= 1'b0;
      rd_win_q    <= 1'b0;
      tag_r_q     <= '0;
      tag_c_q     <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      c_q         <= c_d;
      r_q         <= r_d;
      buf_en_q    <= rd_en;
      // Tag the read that completes a column of a window; it lands in the buffer next cycle.
      rd_win_q    <= rd_en && (k_q == K_LAST) && (c_q >= C_WIN_MIN);
      tag_r_q     <= r_q;
      tag_c_q     <= c_q;
      win_valid_q <= rd_win_q;
      if (rd_win_q) begin
        win_row_q <= tag_r_q;
        win_col_q <= tag_c_q - C_WIN_MIN;
      end
    end
  end

  assign mem_rd_en = rd_en;
  assign mem_addr  = (ADDR_W'(r_q) + ADDR_W'(k_q)) * ADDR_W'(IMG_W) + ADDR_W'(c_q);
  assign buf_en    = buf_en_q;
  assign buf_d     = buf_en_q ? mem_rdata : '0;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

`ifdef LINE_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (state_q == S_RUN && pause && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_line_feeder_nx2d.sv
`timescale 1ns/1ps
// Randomized bench for line_feeder_nx2d: expected read order, windows and window contents
// come from a strip/column/row model of the image and a rotating line-buffer model.
module tb_line_feeder_nx2d;

  localparam int FS = 5;
  localparam int N  = 4;
  localparam int BW = 12;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 16;
  localparam int DW = N * BW;
  localparam int NUM_READS = (H - FS + 1) * W * FS;

  logic          clk = 1'b0;
  logic          rst, start, pause;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          buf_en;
  logic [DW-1:0] buf_d;
  logic          win_valid;
  logic [2:0]    win_row;
  logic [2:0]    win_col;
  logic          busy, done;
`ifdef LINE_FEEDER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  line_feeder_nx2d #(
    .filterSize(FS), .NoOfChannels(N), .filterBitWidth(BW),
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .buf_en(buf_en), .buf_d(buf_d),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .busy(busy), .done(done)
`ifdef LINE_FEEDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // 1-cycle latency image RAM
  logic [DW-1:0] ram [W*H];
  always @(posedge clk) begin
    if (mem_rd_en && mem_addr < AW'(W*H)) mem_rdata <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int            exp_addr[$];
  int            exp_wr[$];
  int            exp_wc[$];
  logic [DW-1:0] lb [FS][W];
  int            reads, writes, wins, dones, exp_stall;
  bit            pend_valid;
  int            pend_addr;

  task automatic fill_ram();
    for (int i = 0; i < W*H; i++) ram[i] = {$urandom, $urandom};
  endtask

  task automatic model_reset();
    exp_addr.delete();
    exp_wr.delete();
    exp_wc.delete();
    for (int r = 0; r <= H - FS; r++)
      for (int c = 0; c < W; c++)
        for (int k = 0; k < FS; k++) exp_addr.push_back((r + k) * W + c);
    for (int r = 0; r <= H - FS; r++)
      for (int c = 0; c <= W - FS; c++) begin
        exp_wr.push_back(r);
        exp_wc.push_back(c);
      end
    reads = 0; writes = 0; wins = 0; dones = 0; exp_stall = 0;
    pend_valid = 1'b0;
    pend_addr  = 0;
  endtask

  // Called once per cycle at the falling edge.
  task automatic sample();
    int er, ec, a, slot, col;
    if (win_valid) begin
      wins++;
      if (exp_wr.size() == 0) begin
        check("win_extra", 1, 0);
      end else begin
        er = exp_wr.pop_front();
        ec = exp_wc.pop_front();
        check("win_row", win_row, er);
        check("win_col", win_col, ec);
        for (int k = 0; k < FS; k++)
          for (int j = 0; j < FS; j++)
            check("win_data", lb[k][ec+j], ram[(er+k)*W + ec + j]);
      end
    end
    check("buf_en", buf_en, pend_valid);
    if (buf_en) begin
      if (pend_valid && pend_addr < W*H) check("buf_d", buf_d, ram[pend_addr]);
      slot = writes % FS;
      col  = (writes / FS) % W;
      lb[slot][col] = buf_d;
      writes++;
    end
    if (pause && exp_addr.size() > 0) exp_stall++;
    pend_valid = mem_rd_en;
    if (mem_rd_en) begin
      reads++;
      pend_addr = int'(mem_addr);
      if (exp_addr.size() == 0) begin
        check("read_extra", 1, 0);
      end else begin
        a = exp_addr.pop_front();
        check("mem_addr", mem_addr, a);
      end
    end
    if (done) dones++;
  endtask

  task automatic run_frame(input int pause_pct, input bit burst7, input bit start_mid,
                           input bit abort40);
    int cyc, burst_left;
    bit fired;
    model_reset();
    @(posedge clk); #1;
    start = 1'b1;
    pause = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; burst_left = 0; fired = 1'b0;
    while (1) begin
      if (burst7 && !fired && reads == 7) begin
        burst_left = 3;
        fired      = 1'b1;
      end
      if (burst_left > 0) begin
        pause = 1'b1;
        burst_left--;
      end else begin
        pause = ($urandom_range(99) < pause_pct);
      end
      if (start_mid) start = (cyc == 20);
      @(negedge clk);
      cyc++;
      sample();
      if (abort40 && reads == 40) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        pause = 1'b0;
        @(negedge clk);
        check("abort_rd_en", mem_rd_en, 0);
        check("abort_buf_en", buf_en, 0);
        check("abort_busy", busy, 0);
        return;
      end
      if (done) break;
      if (cyc > 1000) begin
        check("frame_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    pause = 1'b0;
    check("reads", reads, NUM_READS);
    check("writes", writes, NUM_READS);
    check("wins", wins, (H - FS + 1) * (W - FS + 1));
    check("done_cycle", cyc, NUM_READS + 2 + exp_stall);
    check("busy_at_done", busy, 1);
`ifdef LINE_FEEDER_STALL_CNT_EN
    check("stall_cnt", stall_cnt, exp_stall);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample();
      check("busy_idle", busy, 0);
    end
    check("done_pulses", dones, 1);
    check("reads_after", reads, NUM_READS);
    check("win_row_hold", win_row, H - FS);
    check("win_col_hold", win_col, W - FS);
`ifdef LINE_FEEDER_STALL_CNT_EN
    check("stall_hold", stall_cnt, exp_stall);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    fill_ram();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_buf_en", buf_en, 0);
    check("rst_buf_d", buf_d, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_row", win_row, 0);
    check("rst_win_col", win_col, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef LINE_FEEDER_STALL_CNT_EN
    check("rst_stall", stall_cnt, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(0, 1'b0, 1'b0, 1'b0);   // plain frame
    fill_ram();
    run_frame(0, 1'b1, 1'b0, 1'b0);   // 3-cycle pause after read #7
    fill_ram();
    run_frame(25, 1'b0, 1'b1, 1'b0);  // random pauses, start pulsed while busy
    run_frame(10, 1'b0, 1'b0, 1'b1);  // reset at read #40
    fill_ram();
    run_frame(0, 1'b0, 1'b0, 1'b0);   // restart from address 0 after abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
